// File: rtl/as_gpio_sink.sv
// rtl/as_gpio_sink.sv - GPIO write sink: register bank, event FIFO and run/pass/fail status FSM
// Optional feature macro: AS_GPIO_WRCNT_EN (adds saturating accepted-write counter wr_cnt_o)
module as_gpio_sink #(
    parameter int GPIO_W      = 64,
    parameter int ADDR_W      = 8,
    parameter int NUM_REGS    = 8,
    parameter int STATUS_ADDR = 4,
    parameter int PASS_CODE   = 55,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cs_i,
    input  logic [ADDR_W-1:0] gpio_addr_i,
    input  logic [GPIO_W-1:0] gpio_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [GPIO_W-1:0] rd_data_o,
    output logic              led_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              err_addr_o,
    output logic              ovf_o,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [ADDR_W-1:0] evt_addr_o,
    output logic [GPIO_W-1:0] evt_data_o
`ifdef AS_GPIO_WRCNT_EN
    ,output logic [31:0]      wr_cnt_o
`endif
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W:0] NREG_L = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    logic [GPIO_W-1:0] regs [NUM_REGS];

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [GPIO_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    state_t state_q;
    state_t state_d;
    logic   led_d;
    logic   pass_d;
    logic   fail_d;

    logic wr_in_range;
    logic rd_in_range;
    logic push;
    logic pop;
    logic full;
    logic do_push;
    logic status_wr;
    logic is_run_code;

    assign wr_in_range = ({1'b0, gpio_addr_i} < NREG_L);
    assign rd_in_range = ({1'b0, rd_addr_i} < NREG_L);
    assign push        = cs_i && wr_in_range;
    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign evt_valid_o = (count != '0);
    assign pop         = evt_valid_o && evt_ready_i;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push     = push && (!full || pop);
    assign status_wr   = push && (gpio_addr_i == ADDR_W'(STATUS_ADDR));
    assign is_run_code = (gpio_i == '0) || (gpio_i == GPIO_W'(2));

    // Head is gated so stale storage never leaks out while empty.
    assign evt_addr_o = evt_valid_o ? fifo_addr[rd_ptr] : '0;
    assign evt_data_o = evt_valid_o ? fifo_data[rd_ptr] : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            rd_data_o  <= '0;
            err_addr_o <= 1'b0;
        end else begin
            if (push) begin
                regs[gpio_addr_i[IDX_W-1:0]] <= gpio_i;
            end
            if (cs_i && !wr_in_range) begin
                err_addr_o <= 1'b1;
            end
            rd_data_o <= rd_in_range ? regs[rd_addr_i[IDX_W-1:0]] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            fifo_addr[wr_ptr] <= gpio_addr_i;
            fifo_data[wr_ptr] <= gpio_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !pop) begin
                count <= count + 1'b1;
            end else if (!do_push && pop) begin
                count <= count - 1'b1;
            end
            if (push && full && !pop) begin
                ovf_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            led_o   <= 1'b0;
            pass_o  <= 1'b0;
            fail_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_o   <= led_d;
            pass_o  <= pass_d;
            fail_o  <= fail_d;
        end
    end

    // PASS and FAIL have no exits, which keeps pass_o and fail_o exclusive.
    always_comb begin
        state_d = state_q;
        led_d   = led_o;
        pass_d  = pass_o;
        fail_d  = fail_o;
        if (status_wr && (state_q == ST_IDLE || state_q == ST_RUN)) begin
            if (is_run_code) begin
                state_d = ST_RUN;
                led_d   = gpio_i[1];
            end else if (gpio_i == GPIO_W'(PASS_CODE)) begin
                state_d = ST_PASS;
                pass_d  = 1'b1;
            end else begin
                state_d = ST_FAIL;
                fail_d  = 1'b1;
            end
        end
    end

`ifdef AS_GPIO_WRCNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_cnt_o <= '0;
        end else if (push && (state_q == ST_IDLE || state_q == ST_RUN)
                     && (wr_cnt_o != 32'hFFFF_FFFF)) begin
            wr_cnt_o <= wr_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_as_gpio_sink.sv
// tb/tb_as_gpio_sink.sv - directed self-checking bench for as_gpio_sink
module tb_as_gpio_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs = 1'b0;
    logic [7:0]  gpio_addr = '0;
    logic [63:0] gpio = '0;
    logic [7:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic        led;
    logic        pass;
    logic        fail;
    logic        err_addr;
    logic        ovf;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [7:0]  evt_addr;
    logic [63:0] evt_data;
`ifdef AS_GPIO_WRCNT_EN
    logic [31:0] wr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    as_gpio_sink dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cs_i        (cs),
        .gpio_addr_i (gpio_addr),
        .gpio_i      (gpio),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .led_o       (led),
        .pass_o      (pass),
        .fail_o      (fail),
        .err_addr_o  (err_addr),
        .ovf_o       (ovf),
        .evt_valid_o (evt_valid),
        .evt_ready_i (evt_ready),
        .evt_addr_o  (evt_addr),
        .evt_data_o  (evt_data)
`ifdef AS_GPIO_WRCNT_EN
        ,.wr_cnt_o   (wr_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        cs = 1'b0;
        evt_ready = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [63:0] d);
        cs = 1'b1;
        gpio_addr = a;
        gpio = d;
        @(negedge clk);
        cs = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_pass", pass, 1'b0);
        chk("rst_fail", fail, 1'b0);
        chk("rst_led", led, 1'b0);
        chk("rst_err", err_addr, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_evt_addr", evt_addr, 8'h0);
        chk("rst_evt_data", evt_data, 64'h0);
        chk("rst_rd_data", rd_data, 64'h0);

        do_write(8'd4, 64'd2);
        chk("run_led1", led, 1'b1);
        chk("first_push_valid", evt_valid, 1'b1);
        chk("first_push_addr", evt_addr, 8'd4);
        chk("first_push_data", evt_data, 64'd2);
        do_write(8'd4, 64'd0);
        chk("run_led0", led, 1'b0);
        chk("run_pass", pass, 1'b0);
        chk("run_fail", fail, 1'b0);
        rd_addr = 8'd4;
        @(negedge clk);
        chk("rd_reg4_zero", rd_data, 64'h0);
        evt_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("drain_empty", evt_valid, 1'b0);

        do_write(8'd4, 64'd55);
        chk("pass_set", pass, 1'b1);
        chk("pass_nofail", fail, 1'b0);
        do_write(8'd4, 64'd9);
        chk("pass_sticky", pass, 1'b1);
        chk("pass_sticky_nofail", fail, 1'b0);
        @(negedge clk);
        chk("rd_reg4_9", rd_data, 64'd9);

        rd_addr = 8'd3;
        @(negedge clk);
        do_write(8'd3, 64'h77);
        chk("rd_no_bypass", rd_data, 64'h0);
        @(negedge clk);
        chk("rd_after_write", rd_data, 64'h77);
        rd_addr = 8'd9;
        @(negedge clk);
        chk("rd_out_of_range", rd_data, 64'h0);

        do_reset();
        do_write(8'd4, 64'h13);
        chk("fail_set", fail, 1'b1);
        chk("fail_nopass", pass, 1'b0);
        chk("fail_led", led, 1'b0);
        do_write(8'd4, 64'd55);
        chk("fail_terminal_pass", pass, 1'b0);
        chk("fail_terminal_fail", fail, 1'b1);

        do_reset();
        rd_addr = 8'd1;
        for (int i = 1; i <= 5; i++) begin
            do_write(8'd1, 64'(i));
        end
        chk("ovf_set", ovf, 1'b1);
        chk("ovf_head_addr", evt_addr, 8'd1);
        @(negedge clk);
        chk("ovf_reg1_5", rd_data, 64'd5);
        evt_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_pop_valid", evt_valid, 1'b1);
            chk("ovf_pop_data", evt_data, 64'(i));
            @(negedge clk);
        end
        chk("ovf_drained", evt_valid, 1'b0);
        chk("ovf_sticky", ovf, 1'b1);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_write(8'd2, 64'h10 + 64'(i));
        end
        chk("full_no_ovf", ovf, 1'b0);
        evt_ready = 1'b1;
        do_write(8'd2, 64'hAA);
        chk("pushpop_no_ovf", ovf, 1'b0);
        chk("pushpop_head", evt_data, 64'h11);
        chk("pushpop_v1", evt_valid, 1'b1);
        @(negedge clk);
        chk("pushpop_d2", evt_data, 64'h12);
        @(negedge clk);
        chk("pushpop_d3", evt_data, 64'h13);
        @(negedge clk);
        chk("pushpop_last", evt_data, 64'hAA);
        chk("pushpop_last_addr", evt_addr, 8'd2);
        @(negedge clk);
        chk("pushpop_empty", evt_valid, 1'b0);
        evt_ready = 1'b0;

`ifdef AS_GPIO_WRCNT_EN
        chk("wrcnt_before", wr_cnt, 32'd5);
`endif
        do_write(8'd9, 64'h5A);
        chk("err_set", err_addr, 1'b1);
        chk("err_no_push", evt_valid, 1'b0);
        chk("err_no_fsm", pass | fail, 1'b0);
`ifdef AS_GPIO_WRCNT_EN
        chk("wrcnt_after", wr_cnt, 32'd5);
`endif

        do_write(8'd4, 64'd55);
        chk("pre_rst_pass", pass, 1'b1);
        cs = 1'b1;
        gpio_addr = 8'd3;
        gpio = 64'd7;
        rd_addr = 8'd4;
        #2 rst = 1'b0;
        #1;
        chk("arst_pass", pass, 1'b0);
        chk("arst_err", err_addr, 1'b0);
        chk("arst_valid", evt_valid, 1'b0);
        chk("arst_evt_data", evt_data, 64'h0);
        chk("arst_rd_data", rd_data, 64'h0);
        chk("arst_ovf", ovf, 1'b0);
        cs = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rd", rd_data, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
